// File: rtl/display_mux_7seg_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_mux_7seg_if : BCD digit load and 7-segment drive bundle   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface display_mux_7seg_if;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic       valido;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output dezena,
        output unidade,
        output valido,
        input  seg,
        input  an
    );

    modport slave (
        input  dezena,
        input  unidade,
        input  valido,
        output seg,
        output an
    );
endinterface
`default_nettype wire

// File: rtl/display_mux_7seg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | display_mux_7seg : two-digit multiplexed 7-segment driver with    |
// | blanking gaps. Option macro: LEADING_ZERO_BLANK_EN. Rev 1.0       |
// +------------------------------------------------------------------+
module display_mux_7seg #(
    parameter int DIV = 50000,
    parameter int GAP = 16
) (
    input  wire                    clk,
    input  wire                    rst_n,
    display_mux_7seg_if.slave      bus
);

    typedef enum logic [1:0] {
        SHOW_U = 2'd0,
        GAP_U  = 2'd1,
        SHOW_D = 2'd2,
        GAP_D  = 2'd3
    } state_t;

    localparam logic [15:0] SHOW_LAST = 16'(DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
    localparam bit          HAS_GAP   = (GAP != 0);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        running;
    logic [3:0]  cap_u, cap_d;
    logic [3:0]  disp_u, disp_d, disp_u_nx, disp_d_nx;
    logic [6:0]  seg_reg, seg_nx;
    logic [1:0]  an_reg, an_nx;

    function automatic logic [6:0] encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h3F;
        endcase
        return code;
    endfunction

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 16'd1;
        disp_u_nx = disp_u;
        disp_d_nx = disp_d;
        an_nx     = 2'b11;
        seg_nx    = 7'h7F;

        // First edge out of reset is itself an entry into SHOW_U.
        if (!running) begin
            state_nx = SHOW_U;
            cnt_nx   = 16'd0;
        end else begin
            case (state)
                SHOW_U:  if (cnt == SHOW_LAST) state_nx = HAS_GAP ? GAP_U : SHOW_D;
                GAP_U:   if (cnt == GAP_LAST)  state_nx = SHOW_D;
                SHOW_D:  if (cnt == SHOW_LAST) state_nx = HAS_GAP ? GAP_D : SHOW_U;
                GAP_D:   if (cnt == GAP_LAST)  state_nx = SHOW_U;
                default: state_nx = SHOW_U;
            endcase
            if (state_nx != state) cnt_nx = 16'd0;
        end

        // Display only reloads at frame start, using the pre-edge capture.
        if (state_nx == SHOW_U && (!running || state != SHOW_U)) begin
            disp_u_nx = cap_u;
            disp_d_nx = cap_d;
        end

        case (state_nx)
            SHOW_U: begin
                an_nx  = 2'b10;
                seg_nx = encode(disp_u_nx);
            end
            SHOW_D: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (disp_d_nx != 4'd0) begin
                    an_nx  = 2'b01;
                    seg_nx = encode(disp_d_nx);
                end
`else
                an_nx  = 2'b01;
                seg_nx = encode(disp_d_nx);
`endif
            end
            default: begin
                an_nx  = 2'b11;
                seg_nx = 7'h7F;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= SHOW_U;
            cnt     <= 16'd0;
            running <= 1'b0;
            cap_u   <= 4'd0;
            cap_d   <= 4'd0;
            disp_u  <= 4'd0;
            disp_d  <= 4'd0;
            an_reg  <= 2'b11;
            seg_reg <= 7'h7F;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            running <= 1'b1;
            disp_u  <= disp_u_nx;
            disp_d  <= disp_d_nx;
            an_reg  <= an_nx;
            seg_reg <= seg_nx;
            if (bus.valido) begin
                cap_u <= bus.unidade;
                cap_d <= bus.dezena;
            end
        end
    end

    assign bus.seg = seg_reg;
    assign bus.an  = an_reg;

endmodule
`default_nettype wire
